// File: rtl/rc_mc_pipe_pkg.sv
// Shared port indices, FSM states and helpers for the route-computation stage.
// Port order N,E,S,W,L also defines the order in which multicast branches are emitted.
package rc_mc_pipe_pkg;

    localparam int NUM_PORT = 5;
    localparam int PORT_N   = 0;
    localparam int PORT_E   = 1;
    localparam int PORT_S   = 2;
    localparam int PORT_W   = 3;
    localparam int PORT_L   = 4;

    typedef logic [NUM_PORT-1:0] port_vec_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_e;

    // Isolates the lowest set bit, i.e. the next port in N,E,S,W,L order.
    function automatic port_vec_t lowest_onehot(input port_vec_t v);
        return v & (~v + port_vec_t'(1));
    endfunction

endpackage

// File: rtl/rc_mc_pipe_split.sv
// Combinational XY partition of a destination bitmask into one sub-list per output port.
// Zero latency, no flow control; node coordinates are elaboration-time constants per bit.
module rc_mc_pipe_split
    import rc_mc_pipe_pkg::*;
#(
    parameter int MESH_X         = 4,
    parameter int COORD_W        = 2,
    parameter int DST_LIST_WIDTH = 16
) (
    input  logic [COORD_W-1:0]                      cur_x_i,
    input  logic [COORD_W-1:0]                      cur_y_i,
    input  logic [DST_LIST_WIDTH-1:0]               dst_list_i,
    output logic [NUM_PORT-1:0][DST_LIST_WIDTH-1:0] sub_list_o
);

    for (genvar i = 0; i < DST_LIST_WIDTH; i++) begin : g_node
        localparam logic [COORD_W-1:0] NX = COORD_W'(i % MESH_X);
        localparam logic [COORD_W-1:0] NY = COORD_W'(i / MESH_X);

        logic [NUM_PORT-1:0] sel;

        // X is resolved first; N means increasing y.
        always_comb begin
            sel = '0;
            if (NX > cur_x_i) begin
                sel[PORT_E] = 1'b1;
            end else if (NX < cur_x_i) begin
                sel[PORT_W] = 1'b1;
            end else if (NY > cur_y_i) begin
                sel[PORT_N] = 1'b1;
            end else if (NY < cur_y_i) begin
                sel[PORT_S] = 1'b1;
            end else begin
                sel[PORT_L] = 1'b1;
            end
        end

        for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
            assign sub_list_o[p][i] = dst_list_i[i] & sel[p];
        end
    end

endmodule

// File: rtl/rc_mc_pipe.sv
// Registered XY route computation with multicast fork: first branch 1 cycle after accept, then 1 branch/cycle.
// Branch outputs hold while out_valid & !out_ready; in_ready only in IDLE when the output slot frees.
module rc_mc_pipe
    import rc_mc_pipe_pkg::*;
#(
    parameter int MESH_X         = 4,
    parameter int MESH_Y         = 4,
    parameter int COORD_W        = 2,
    parameter int DST_LIST_WIDTH = MESH_X * MESH_Y
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [COORD_W-1:0]        cur_x,
    input  logic [COORD_W-1:0]        cur_y,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mc,
    input  logic [COORD_W-1:0]        in_dst_x,
    input  logic [COORD_W-1:0]        in_dst_y,
    input  logic [DST_LIST_WIDTH-1:0] in_dst_list,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_PORT-1:0]       out_ppv,
    output logic [NUM_PORT-1:0]       out_port,
    output logic [DST_LIST_WIDTH-1:0] out_dst_list,
    output logic                      out_last,
    output logic                      err
);

    typedef logic [DST_LIST_WIDTH-1:0] dst_t;

    localparam logic [31:0] MX_L = 32'(MESH_X);
    localparam logic [31:0] MY_L = 32'(MESH_Y);

    state_e                 state_q;
    logic                   valid_q;
    port_vec_t              ppv_q;
    port_vec_t              port_q;
    dst_t                   dst_q;
    logic                   last_q;
    logic                   err_q;
    port_vec_t              pend_q;
    dst_t [NUM_PORT-1:0]    subl_q;

    logic                   uc_ok;
    logic [31:0]            uc_idx;
    dst_t                   uc_onehot;
    dst_t                   split_in;
    dst_t [NUM_PORT-1:0]    sub_c;
    port_vec_t              ppv_c;
    port_vec_t              first_c;
    port_vec_t              rest_c;
    dst_t                   first_sub;
    port_vec_t              next_c;
    port_vec_t              pend_nxt;
    dst_t                   next_sub;
    logic                   accept;

    // Unicast reuses the multicast partition via a one-hot list; an off-mesh
    // destination yields an empty list and is dropped like an empty multicast.
    assign uc_ok     = (32'(in_dst_x) < MX_L) && (32'(in_dst_y) < MY_L);
    assign uc_idx    = 32'(in_dst_y) * MX_L + 32'(in_dst_x);
    assign uc_onehot = uc_ok ? (dst_t'(1) << uc_idx) : '0;
    assign split_in  = in_mc ? in_dst_list : uc_onehot;

    rc_mc_pipe_split #(
        .MESH_X         (MESH_X),
        .COORD_W        (COORD_W),
        .DST_LIST_WIDTH (DST_LIST_WIDTH)
    ) u_split (
        .cur_x_i    (cur_x),
        .cur_y_i    (cur_y),
        .dst_list_i (split_in),
        .sub_list_o (sub_c)
    );

    always_comb begin
        ppv_c     = '0;
        first_sub = '0;
        next_sub  = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            ppv_c[p] = |sub_c[p];
        end
        first_c  = lowest_onehot(ppv_c);
        rest_c   = ppv_c & ~first_c;
        next_c   = lowest_onehot(pend_q);
        pend_nxt = pend_q & ~next_c;
        for (int p = 0; p < NUM_PORT; p++) begin
            if (first_c[p]) first_sub = first_sub | sub_c[p];
            if (next_c[p])  next_sub  = next_sub | subl_q[p];
        end
    end

    assign in_ready = reset_n && (state_q == ST_IDLE) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ppv_q   <= '0;
            port_q  <= '0;
            dst_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= '0;
            subl_q  <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid_q && out_ready) begin
                        valid_q <= 1'b0;
                    end
                    if (accept) begin
                        if (ppv_c == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            valid_q <= 1'b1;
                            ppv_q   <= ppv_c;
                            port_q  <= first_c;
                            dst_q   <= first_sub;
                            last_q  <= (rest_c == '0);
                            pend_q  <= rest_c;
                            subl_q  <= sub_c;
                            state_q <= (rest_c == '0) ? ST_IDLE : ST_SPLIT;
                        end
                    end
                end
                ST_SPLIT: begin
                    // The final branch is presented from IDLE so the next
                    // header can be taken in the cycle it is consumed.
                    if (out_ready) begin
                        port_q <= next_c;
                        dst_q  <= next_sub;
                        pend_q <= pend_nxt;
                        if (pend_nxt == '0) begin
                            last_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid    = valid_q;
    assign out_ppv      = ppv_q;
    assign out_port     = port_q;
    assign out_dst_list = dst_q;
    assign out_last     = last_q;
    assign err          = err_q;

endmodule
